// File: rtl/boot_rom_loader.sv
// boot_rom_loader
// Copies COUNT consecutive 32-bit words from the boot ROM (starting at word
// SRC_BASE) into instruction RAM (starting at byte address DST_BASE) after a
// single-cycle START pulse. It reports completion with DONE and a wrapping
// 32-bit CHECKSUM of the copied words.
//
// Ports
//   CLK, RST         clock, synchronous active-high reset
//   START            copy request, only honoured in IDLE
//   BUSY, DONE       copy in progress / one-cycle completion pulse
//   CHECKSUM         wrapping sum of copied words, held until next START
//   ROM_CSN, ROM_A   ROM read port (active-low select, word address)
//   ROM_Q            ROM data for the address captured at the last selected edge
//   RAM_REQ/GNT      write handshake, accepted when both are high on an edge
//   RAM_WE, RAM_BE   write enable / byte enables, active only with RAM_REQ
//   RAM_ADDR/WDATA   write byte address / data, zero when RAM_REQ is low
module boot_rom_loader #(
  parameter int          COUNT    = 548,
  parameter int          SRC_BASE = 0,
  parameter logic [31:0] DST_BASE = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] CHECKSUM,
  output logic        ROM_CSN,
  output logic [9:0]  ROM_A,
  input  logic [31:0] ROM_Q,
  output logic        RAM_REQ,
  input  logic        RAM_GNT,
  output logic        RAM_WE,
  output logic [31:0] RAM_ADDR,
  output logic [31:0] RAM_WDATA,
  output logic [3:0]  RAM_BE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  // 11 bits so that COUNT=1024 is representable in the end-of-copy compare.
  localparam logic [10:0] COUNT_L = 11'(COUNT);
  localparam logic [9:0]  SRC_L   = 10'(SRC_BASE);

  state_t      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [31:0] checksum_q, checksum_d;
  logic [10:0] idx_inc;
  logic        more_words;

  // Modulo-2^32 accumulate; the carry out is deliberately discarded.
  function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[31:0];
  endfunction

  assign idx_inc    = {1'b0, idx_q} + 11'd1;
  assign more_words = (idx_inc < COUNT_L);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    checksum_d = checksum_q;
    BUSY       = 1'b0;
    DONE       = 1'b0;
    ROM_CSN    = 1'b1;
    ROM_A      = 10'd0;
    RAM_REQ    = 1'b0;
    RAM_ADDR   = 32'd0;
    RAM_WDATA  = 32'd0;

    case (state_q)
      IDLE: begin
        if (START) begin
          idx_d      = 10'd0;
          checksum_d = 32'd0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        BUSY    = 1'b1;
        ROM_CSN = 1'b0;
        ROM_A   = SRC_L;
        state_d = WRITE;
      end
      WRITE: begin
        BUSY      = 1'b1;
        RAM_REQ   = 1'b1;
        RAM_ADDR  = DST_BASE + {20'd0, idx_q, 2'b00};
        // ROM_Q is stable while stalled because ROM_CSN stays high until the grant.
        RAM_WDATA = ROM_Q;
        if (RAM_GNT) begin
          checksum_d = wrap_add(checksum_q, ROM_Q);
          idx_d      = idx_inc[9:0];
          if (more_words) begin
            // Prefetch the next word on the same edge the current one is accepted.
            ROM_CSN = 1'b0;
            ROM_A   = SRC_L + idx_q + 10'd1;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        DONE    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences the bus in the very cycle it is asserted, so an
    // in-flight request is dropped rather than completed.
    if (RST) begin
      BUSY      = 1'b0;
      DONE      = 1'b0;
      ROM_CSN   = 1'b1;
      ROM_A     = 10'd0;
      RAM_REQ   = 1'b0;
      RAM_ADDR  = 32'd0;
      RAM_WDATA = 32'd0;
    end
  end

  assign RAM_WE   = RAM_REQ;
  assign RAM_BE   = RAM_REQ ? 4'hF : 4'h0;
  assign CHECKSUM = RST ? 32'd0 : checksum_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= 10'd0;
      checksum_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      checksum_q <= checksum_d;
    end
  end

endmodule
